shot_slot_scheduler: RTL and testbench
======================================

Name: shot_slot_scheduler

Overview:
- Sequences the player-shot pool: decides when a shot may fire and which of the N shot slots receives the one-cycle deploy pulse.
- Tracks slot occupancy and returns slots to the pool on hit or retire pulses.
- Enforces a frame-based fire cooldown, with a shorter cooldown in rapid-fire mode.
- Sits between the player inputs and the shot datapath; it replaces ad-hoc deploy_shot generation in the game controller.

Parameters:
- N_SLOTS, 8, number of shot slots; deploy and release vectors are N_SLOTS wide.
- SLOW_CD, 12, cooldown in frames between shots when rapid_fire=0.
- FAST_CD, 3, cooldown in frames when rapid_fire=1.
- CD_W, 5, cooldown counter width; must satisfy 2^CD_W > max(SLOW_CD, FAST_CD).

Ports:
- clk  in  1  system clock (50 MHz).
- resetN  in  1  synchronous reset, active-high: asserted value is 1 and is sampled on the clk rising edge. The name is kept for codebase consistency.
- startOfFrame  in  1  one-cycle pulse per VGA frame.
- shoot  in  1  level fire request from the player.
- player_active  in  1  player alive/controllable.
- rapid_fire  in  1  selects FAST_CD.
- slot_release  in  N_SLOTS  per-slot retire pulse, from a collision hit or the shot leaving the screen.
- deploy_shot  out  N_SLOTS  one-hot, one-cycle deploy pulse.
- slots_busy  out  N_SLOTS  occupancy mask.
- shots_in_flight  out  $clog2(N_SLOTS+1)  popcount of slots_busy.
- cooldown_active  out  1  high while in COOLDOWN.

Behaviour:
- Reset (resetN=1 at clk edge):
  - State = IDLE; slots_busy = 0; deploy_shot = 0; cd_cnt = 0.
  - shots_in_flight = 0; cooldown_active = 0.
  - A reset mid-FIRE suppresses the pending pulse.
- States are IDLE, FIRE and COOLDOWN.
- IDLE:
  - Fire condition: startOfFrame & shoot & player_active & (slots_busy != all-ones).
  - When the condition holds, go to FIRE next cycle and latch sel = index of the lowest free slot, computed from slots_busy in that cycle.
- FIRE (exactly 1 cycle):
  - deploy_shot = 1<<sel; slots_busy[sel] set.
  - cd_cnt loaded with rapid_fire ? FAST_CD : SLOW_CD, sampled in this cycle.
  - Go to COOLDOWN.
  - If player_active=0 in this cycle: no pulse, no allocation, return to IDLE.
- COOLDOWN:
  - On each startOfFrame, cd_cnt decrements.
  - When a startOfFrame arrives with cd_cnt==1, go to IDLE. The IDLE fire check is therefore first evaluated on the following startOfFrame, so the minimum period is CD+1 frames.
  - player_active=0 → go to IDLE immediately and clear cd_cnt.
- Release:
  - slot_release[i] clears slots_busy[i] on the next edge, in any state.
  - A release of an already-free slot is ignored.
- Simultaneous set and release of the same slot in FIRE: the set wins. This cannot normally happen, because sel was chosen from a free slot.
- Pool full at startOfFrame: stay in IDLE. No retry until the next startOfFrame.
- shoot is level-sensitive. Holding it produces auto-fire at the cooldown rate.
- shots_in_flight is registered and matches slots_busy in the same cycle.
- deploy_shot is registered. Latency from the startOfFrame edge to the deploy pulse is 1 cycle.

Optional Feature:
- Macro SHOT_BURST_EN.
- Defined:
  - When rapid_fire=1, each accepted trigger fires a burst of 3 shots on 3 consecutive startOfFrames, each shot to the lowest free slot.
  - The burst counter lives in the BURST sub-path of COOLDOWN.
  - The cooldown (FAST_CD) starts after the last burst shot.
  - If the pool fills mid-burst, the burst is truncated.
- Not defined: single shot per trigger as described above; no burst logic is synthesized.

Decomposition:
- Package shot_sched_pkg:
  - state enum sched_state_t {IDLE, FIRE, COOLDOWN}.
  - Default SLOW_CD and FAST_CD constants.
  - BURST_LEN=3.
- Sub-module lsb_free_encoder (combinational, parameter N): takes the busy mask and outputs the index and any_free flag.
- The scheduler FSM, counters and occupancy register stay in the main module.

Test Plan:
1. Reset, then shoot=1, player_active=1, rapid_fire=0, frames every 100 clk → deploy_shot=8'h01 one cycle after the first startOfFrame; next pulse 8'h02 exactly 13 frames later; slots_busy=8'h03, shots_in_flight=2.
2. Fill all 8 slots with rapid_fire=1 → pulses 01,02,…,80 at a 4-frame spacing; the 9th trigger produces no pulse; slot_release=8'h10 → the next fire deploys 8'h10.
3. Release slot 0 in the same cycle FIRE allocates slot 2 (busy=8'h03) → deploy=8'h04 and busy=8'h06 next cycle.
4. player_active drops during COOLDOWN at cd_cnt=7 → immediate IDLE, cooldown_active=0; no deploy while player_active=0.
5. Assert resetN=1 on the cycle of FIRE → no deploy pulse; all outputs zero next cycle; resetN=0 → normal operation on the next startOfFrame.
6. With SHOT_BURST_EN and rapid_fire=1, one trigger → deploys 01,02,04 on three consecutive frames, then 3-frame cooldown; with busy=8'hFC, the burst truncates after slots 0 and 1.

Source files
------------

// File: rtl/shot_slot_scheduler_pkg.sv
// Shared types and default constants for the player-shot slot scheduler.
// BURST_LEN is only referenced when SHOT_BURST_EN is defined.
package shot_sched_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FIRE     = 2'd1,
      COOLDOWN = 2'd2
   } sched_state_t;

   localparam int unsigned DEF_SLOW_CD = 12;
   localparam int unsigned DEF_FAST_CD = 3;
   localparam int unsigned BURST_LEN   = 3;

endpackage

// File: rtl/shot_slot_scheduler_lsb_free_encoder.sv
// Combinational finder for the lowest-index free (zero) bit of a busy mask.
module lsb_free_encoder #(
   parameter int unsigned N     = 8,
   parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     i_busy,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any_free
);

   // Scanning from the top down lets the lowest free bit win the final write.
   always_comb begin
      o_idx      = '0;
      o_any_free = 1'b0;
      for (int unsigned i = N; i > 0; i--) begin
         if (!i_busy[i-1]) begin
            o_idx      = IDX_W'(i - 1);
            o_any_free = 1'b1;
         end
      end
   end

endmodule

// File: rtl/shot_slot_scheduler.sv
// Player-shot pool scheduler: fire gating, lowest-free slot allocation, frame cooldown.
// Define SHOT_BURST_EN to enable 3-shot bursts in rapid-fire mode.
module shot_slot_scheduler
   import shot_sched_pkg::*;
#(
   parameter int unsigned N_SLOTS = 8,
   parameter int unsigned SLOW_CD = DEF_SLOW_CD,
   parameter int unsigned FAST_CD = DEF_FAST_CD,
   parameter int unsigned CD_W    = 5
) (
   input  logic                         clk,
   input  logic                         resetN,
   input  logic                         startOfFrame,
   input  logic                         shoot,
   input  logic                         player_active,
   input  logic                         rapid_fire,
   input  logic [N_SLOTS-1:0]           slot_release,
   output logic [N_SLOTS-1:0]           deploy_shot,
   output logic [N_SLOTS-1:0]           slots_busy,
   output logic [$clog2(N_SLOTS+1)-1:0] shots_in_flight,
   output logic                         cooldown_active
);

   localparam int unsigned IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
   localparam int unsigned CNT_W = $clog2(N_SLOTS + 1);
   localparam logic [N_SLOTS-1:0] ONE = {{(N_SLOTS-1){1'b0}}, 1'b1};

   sched_state_t       r_state, w_state_nxt;
   logic [IDX_W-1:0]   r_sel, w_sel_nxt;
   logic [CD_W-1:0]    r_cd, w_cd_nxt;
   logic [N_SLOTS-1:0] r_busy, w_busy_nxt;
   logic [N_SLOTS-1:0] r_deploy, w_deploy_nxt;
   logic [N_SLOTS-1:0] w_set;
   logic [CNT_W-1:0]   r_inflight, w_inflight_nxt;
   logic [IDX_W-1:0]   w_free_idx;
   logic               w_any_free;
`ifdef SHOT_BURST_EN
   localparam int unsigned BURST_W = 2;
   logic [BURST_W-1:0] r_burst, w_burst_nxt;
`endif

   lsb_free_encoder #(
      .N     (N_SLOTS),
      .IDX_W (IDX_W)
   ) u_enc (
      .i_busy     (r_busy),
      .o_idx      (w_free_idx),
      .o_any_free (w_any_free)
   );

   always_ff @(posedge clk) begin
      if (resetN) begin
         r_state    <= IDLE;
         r_sel      <= '0;
         r_cd       <= '0;
         r_busy     <= '0;
         r_deploy   <= '0;
         r_inflight <= '0;
`ifdef SHOT_BURST_EN
         r_burst    <= '0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_sel      <= w_sel_nxt;
         r_cd       <= w_cd_nxt;
         r_busy     <= w_busy_nxt;
         r_deploy   <= w_deploy_nxt;
         r_inflight <= w_inflight_nxt;
`ifdef SHOT_BURST_EN
         r_burst    <= w_burst_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_sel_nxt    = r_sel;
      w_cd_nxt     = r_cd;
      w_set        = '0;
      w_deploy_nxt = '0;
`ifdef SHOT_BURST_EN
      w_burst_nxt  = r_burst;
`endif
      case (r_state)
         IDLE: begin
            if (startOfFrame && shoot && player_active && w_any_free) begin
               w_state_nxt = FIRE;
               w_sel_nxt   = w_free_idx;
`ifdef SHOT_BURST_EN
               w_burst_nxt = rapid_fire ? BURST_W'(BURST_LEN - 1) : '0;
`endif
            end
         end
         FIRE: begin
            if (player_active) begin
               w_set        = ONE << r_sel;
               w_deploy_nxt = w_set;
               w_cd_nxt     = rapid_fire ? CD_W'(FAST_CD) : CD_W'(SLOW_CD);
               w_state_nxt  = COOLDOWN;
            end else begin
               w_state_nxt = IDLE;
`ifdef SHOT_BURST_EN
               w_burst_nxt = '0;
`endif
            end
         end
         COOLDOWN: begin
            if (!player_active) begin
               w_state_nxt = IDLE;
               w_cd_nxt    = '0;
`ifdef SHOT_BURST_EN
               w_burst_nxt = '0;
            end else if ((r_burst != '0) && startOfFrame && w_any_free) begin
               w_state_nxt = FIRE;
               w_sel_nxt   = w_free_idx;
               w_burst_nxt = r_burst - BURST_W'(1);
`endif
            end else if (startOfFrame) begin
               // A full pool mid-burst drops the remaining shots; that frame already counts toward the cooldown.
`ifdef SHOT_BURST_EN
               w_burst_nxt = '0;
`endif
               if (r_cd <= CD_W'(1)) begin
                  w_state_nxt = IDLE;
                  w_cd_nxt    = '0;
               end else begin
                  w_cd_nxt = r_cd - CD_W'(1);
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cd_nxt    = '0;
         end
      endcase
   end

   // Setting the allocated slot is applied after the release so the set wins on a collision.
   assign w_busy_nxt = (r_busy & ~slot_release) | w_set;

   always_comb begin
      w_inflight_nxt = '0;
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
         w_inflight_nxt = w_inflight_nxt + CNT_W'(w_busy_nxt[i]);
      end
   end

   assign deploy_shot     = r_deploy;
   assign slots_busy      = r_busy;
   assign shots_in_flight = r_inflight;
   assign cooldown_active = (r_state == COOLDOWN);

endmodule

// File: tb/tb_shot_slot_scheduler.sv
// Scoreboard bench for shot_slot_scheduler; burst scenario runs when SHOT_BURST_EN is defined.
`timescale 1ns/1ps
module tb_shot_slot_scheduler;

   logic       clk = 1'b0;
   logic       resetN = 1'b1;
   logic       startOfFrame = 1'b0;
   logic       shoot = 1'b0;
   logic       player_active = 1'b0;
   logic       rapid_fire = 1'b0;
   logic [7:0] slot_release = '0;
   logic [7:0] deploy_shot;
   logic [7:0] slots_busy;
   logic [3:0] shots_in_flight;
   logic       cooldown_active;

   int n_vec = 0;
   int n_err = 0;
   int unsigned cyc = 0;
   int unsigned sof_edge = 0;
   int fr = 0;
   int fr_cur = -1;

   typedef struct {
      int         frame;
      logic [7:0] dep;
      logic [7:0] busy;
      logic [3:0] cnt;
   } exp_t;
   exp_t sb[$];

   shot_slot_scheduler #(
      .N_SLOTS (8),
      .SLOW_CD (12),
      .FAST_CD (3),
      .CD_W    (5)
   ) dut (
      .clk             (clk),
      .resetN          (resetN),
      .startOfFrame    (startOfFrame),
      .shoot           (shoot),
      .player_active   (player_active),
      .rapid_fire      (rapid_fire),
      .slot_release    (slot_release),
      .deploy_shot     (deploy_shot),
      .slots_busy      (slots_busy),
      .shots_in_flight (shots_in_flight),
      .cooldown_active (cooldown_active)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input int f, input logic [7:0] d, input logic [7:0] b, input logic [3:0] c);
      exp_t e;
      e.frame = f; e.dep = d; e.busy = b; e.cnt = c;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // rel and rst_fire are driven in the cycle after the frame pulse, i.e. the FIRE cycle when firing.
   task automatic frame(input logic [7:0] rel, input logic rst_fire);
      startOfFrame = 1'b1;
      sof_edge     = cyc + 1;
      fr_cur       = fr;
      fr++;
      tick();
      startOfFrame = 1'b0;
      slot_release = rel;
      resetN       = rst_fire;
      tick();
      slot_release = '0;
      resetN       = 1'b0;
      repeat (98) tick();
   endtask

   task automatic do_reset();
      resetN = 1'b1;
      repeat (3) tick();
      chk("reset_deploy", 32'(deploy_shot), 0);
      chk("reset_busy", 32'(slots_busy), 0);
      chk("reset_inflight", 32'(shots_in_flight), 0);
      chk("reset_cooldown", 32'(cooldown_active), 0);
      resetN = 1'b0;
      tick();
   endtask

   always @(negedge clk) begin
      if (deploy_shot != '0) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_deploy: got %02h, expected no pulse (t=%0t)", deploy_shot, $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("deploy_value", 32'(deploy_shot), 32'(e.dep));
            chk("deploy_busy", 32'(slots_busy), 32'(e.busy));
            chk("deploy_inflight", 32'(shots_in_flight), 32'(e.cnt));
            chk("deploy_frame", 32'(fr_cur), 32'(e.frame));
            chk("deploy_latency", cyc - sof_edge, 1);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      repeat (2) tick();
      do_reset();

      // Slow cooldown: period 13 frames; third shot coincides with a release of slot 0.
      shoot = 1'b1; player_active = 1'b1; rapid_fire = 1'b0;
      b = fr;
      push(b,      8'h01, 8'h01, 4'd1);
      push(b + 13, 8'h02, 8'h03, 4'd2);
      push(b + 26, 8'h04, 8'h06, 4'd2);
      for (int k = 0; k < 27; k++) begin
         frame((k == 26) ? 8'h01 : 8'h00, 1'b0);
         if (k == 13) begin
            chk("t1_busy", 32'(slots_busy), 32'h03);
            chk("t1_inflight", 32'(shots_in_flight), 2);
            chk("t1_cooldown", 32'(cooldown_active), 1);
         end
      end
      chk("t3_busy", 32'(slots_busy), 32'h06);

      // Drop player_active once cd_cnt has counted down to 7.
      for (int k = 0; k < 5; k++) frame(8'h00, 1'b0);
      chk("t4_cooldown_before", 32'(cooldown_active), 1);
      player_active = 1'b0;
      tick();
      chk("t4_cooldown_after", 32'(cooldown_active), 0);
      for (int k = 0; k < 3; k++) frame(8'h00, 1'b0);
      player_active = 1'b1;
      push(fr, 8'h01, 8'h07, 4'd3);
      frame(8'h00, 1'b0);

      // Force IDLE, then reset during the FIRE cycle.
      player_active = 1'b0;
      tick();
      player_active = 1'b1;
      tick();
      frame(8'h00, 1'b1);
      chk("t5_deploy", 32'(deploy_shot), 0);
      chk("t5_busy", 32'(slots_busy), 0);
      chk("t5_inflight", 32'(shots_in_flight), 0);
      chk("t5_cooldown", 32'(cooldown_active), 0);
      push(fr, 8'h01, 8'h01, 4'd1);
      frame(8'h00, 1'b0);
      shoot = 1'b0;
      repeat (5) tick();

`ifndef SHOT_BURST_EN
      // Rapid fire fills the pool at a 4-frame period; release of slot 4 reopens it.
      do_reset();
      shoot = 1'b1; player_active = 1'b1; rapid_fire = 1'b1;
      b = fr;
      for (int k = 0; k < 35; k++) begin
         if ((k % 4 == 0) && (k < 32))
            push(b + k, 8'(1 << (k / 4)), 8'((2 << (k / 4)) - 1), 4'(k / 4 + 1));
         if (k == 34)
            push(b + k, 8'h10, 8'hFF, 4'd8);
         frame((k == 33) ? 8'h10 : 8'h00, 1'b0);
         if (k == 32) chk("t2_full_idle", 32'(cooldown_active), 0);
         if (k == 33) begin
            chk("t2_release_busy", 32'(slots_busy), 32'hEF);
            chk("t2_release_inflight", 32'(shots_in_flight), 7);
         end
      end
      shoot = 1'b0; rapid_fire = 1'b0;
`else
      // Bursts of three on consecutive frames, truncated when the pool fills.
      do_reset();
      shoot = 1'b1; player_active = 1'b1; rapid_fire = 1'b1;
      b = fr;
      push(b,      8'h01, 8'h01, 4'd1);
      push(b + 1,  8'h02, 8'h03, 4'd2);
      push(b + 2,  8'h04, 8'h07, 4'd3);
      push(b + 6,  8'h08, 8'h0F, 4'd4);
      push(b + 7,  8'h10, 8'h1F, 4'd5);
      push(b + 8,  8'h20, 8'h3F, 4'd6);
      push(b + 12, 8'h40, 8'h7F, 4'd7);
      push(b + 13, 8'h80, 8'hFF, 4'd8);
      for (int k = 0; k < 18; k++) begin
         frame(8'h00, 1'b0);
         if (k == 4) chk("t6_cooldown", 32'(cooldown_active), 1);
         if (k == 5) chk("t6_idle", 32'(cooldown_active), 0);
      end
      shoot = 1'b0;
      frame(8'h03, 1'b0);
      chk("t6_busy_fc", 32'(slots_busy), 32'hFC);
      chk("t6_inflight_fc", 32'(shots_in_flight), 6);
      shoot = 1'b1;
      b = fr;
      push(b,     8'h01, 8'hFD, 4'd7);
      push(b + 1, 8'h02, 8'hFF, 4'd8);
      for (int k = 0; k < 4; k++) frame(8'h00, 1'b0);
      chk("t6_trunc_cooldown", 32'(cooldown_active), 1);
      shoot = 1'b0; rapid_fire = 1'b0;
`endif

      repeat (10) tick();
      chk("scoreboard_drained", 32'(sb.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
